pdm_audio_out: RTL and testbench
================================

PDM_AUDIO_OUT -- requirements
Module: pdm_audio_out

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, bits per audio word.
REQ-002 The module SHALL have parameter CLK_DIV, default 10, clock cycles per output bit (matches the deserializer bit period).
REQ-003 The module SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-004 clock  input  1  sole clock, rising-edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  stage enable; low halts playback and ignores writes.
REQ-007 done  input  1  one-cycle strobe from the upstream deserializer; data valid.
REQ-008 data  input  WIDTH  word captured on done.
REQ-009 audio_out  output  1  serial PDM bitstream to the audio amplifier.
REQ-010 level  output  clog2(DEPTH+1)  number of words currently buffered.
REQ-011 overflow  output  1  one-cycle pulse: incoming word dropped (FIFO full).
REQ-012 underrun  output  1  one-cycle pulse: word finished with FIFO empty.

Function
REQ-013 The module SHALL write data into the FIFO on a rising edge where reset_n=1, enable=1, done=1 and the FIFO is not full after any same-edge pop.
REQ-014 A write attempted when full and no same-edge pop SHALL drop the word, leave FIFO unchanged, and pulse overflow for exactly one cycle.
REQ-015 Simultaneous pop and write on a full FIFO SHALL accept the write; level unchanged.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH exactly.
REQ-017 The state machine SHALL have states IDLE and SHIFT.
REQ-018 IDLE: audio_out=0; if enable=1 and level>0, pop head word into a WIDTH-bit shift register, clear bit and divider counters, drive audio_out=word[WIDTH-1], go SHIFT on the same edge.
REQ-019 SHIFT: divider counts 0..CLK_DIV-1; each bit SHALL be held on audio_out for exactly CLK_DIV cycles, MSB first.
REQ-020 On the edge ending bit 0 (bit counter=WIDTH-1, divider=CLK_DIV-1): if level>0, pop next word and drive its MSB with zero gap, staying in SHIFT; else go IDLE, audio_out=0, pulse underrun one cycle.
REQ-021 One word SHALL occupy exactly WIDTH*CLK_DIV cycles on audio_out.
REQ-022 Latency: done sampled at edge E into an empty FIFO while IDLE SHALL put data[WIDTH-1] on audio_out after edge E+1.
REQ-023 enable=0 SHALL, on the next edge, force IDLE, audio_out=0, clear counters; buffered words SHALL be retained; the interrupted word SHALL be discarded.
REQ-024 overflow and underrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 On an edge with reset_n=0: FIFO emptied (level=0), pointers=0, state=IDLE, counters=0, audio_out=0, overflow=0, underrun=0.
REQ-026 Reset SHALL take priority over done and enable, including mid-word; no underrun pulse on reset.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Reset, enable=1, done pulse with data=16'hA5C3 -> audio_out=1 one cycle later, bit sequence 1010010111000011 each held 10 cycles, then underrun pulse, audio_out=0.
REQ-029 Two words 16'hFFFF, 16'h0000 written 3 cycles apart -> 160 cycles of 1 immediately followed by 160 cycles of 0, no gap, single underrun at end.
REQ-030 enable=1, 6 done pulses on consecutive cycles -> 1 popped, level reaches 4, sixth word dropped with one overflow pulse.
REQ-031 Full FIFO, done coinciding with word-end pop edge -> write accepted, no overflow, level stays 4.
REQ-032 enable dropped mid-word with level=2 -> audio_out=0 next cycle, level=2; enable restored -> next word starts from MSB.
REQ-033 reset_n=0 mid-word with level=3 -> next cycle level=0, audio_out=0, IDLE, no underrun pulse.

Source files
------------

// File: rtl/pdm_audio_out.sv
// rtl/pdm_audio_out.sv - FIFO-buffered serial PDM playback stage
//
// Purpose: buffers audio words delivered by an upstream deserializer and
// replays each one MSB first on a single serial line. Each bit is held for
// CLK_DIV clocks. Back-to-back words play with no gap between them.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset_n   - synchronous, active-low reset
//   enable    - stage enable; low halts playback and ignores writes
//   done      - one-cycle strobe, data is valid
//   data      - WIDTH-bit word captured on done
//   audio_out - serial PDM bitstream (registered)
//   level     - words currently buffered, 0..DEPTH (registered)
//   overflow  - one-cycle pulse: incoming word dropped, FIFO full
//   underrun  - one-cycle pulse: word finished with FIFO empty
module pdm_audio_out #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 10,
   parameter int DEPTH   = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic                         done,
   input  logic [WIDTH-1:0]             data,
   output logic                         audio_out,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic                         underrun
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [LW-1:0] FULL     = LW'(DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;

   logic word_end;
   logic pop;
   logic push;
   logic drop;

   // A pop frees a slot on the same edge, so a write into a full FIFO is
   // still accepted when the head word is being taken at that moment.
   always_comb begin
      word_end = (state == SHIFT) && (bit_cnt == LAST_BIT) && (div_cnt == LAST_DIV);
      pop      = enable && (level != '0) && ((state == IDLE) || word_end);
      push     = enable && done && ((level != FULL) || pop);
      drop     = enable && done && (level == FULL) && !pop;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         audio_out <= 1'b0;
         overflow  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         overflow <= drop;
         underrun <= 1'b0;

         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) begin
            mem[wr_ptr] <= data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase

         if (!enable) begin
            // The interrupted word is abandoned; buffered words stay put.
            state     <= IDLE;
            audio_out <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
         end else if (pop) begin
            // Covers both the start from IDLE and the gapless chain at word end.
            shreg     <= mem[rd_ptr];
            audio_out <= mem[rd_ptr][WIDTH-1];
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= SHIFT;
         end else if (state == SHIFT) begin
            if (word_end) begin
               state     <= IDLE;
               audio_out <= 1'b0;
               underrun  <= 1'b1;
               bit_cnt   <= '0;
               div_cnt   <= '0;
            end else if (div_cnt == LAST_DIV) begin
               div_cnt   <= '0;
               bit_cnt   <= bit_cnt + 1'b1;
               shreg     <= {shreg[WIDTH-2:0], 1'b0};
               audio_out <= shreg[WIDTH-2];
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_audio_out.sv
// tb/tb_pdm_audio_out.sv - scoreboard bench for pdm_audio_out
module tb_pdm_audio_out;

   localparam int WIDTH    = 16;
   localparam int CLK_DIV  = 10;
   localparam int DEPTH    = 4;
   localparam int LW       = $clog2(DEPTH + 1);
   localparam int WORD_CYC = WIDTH * CLK_DIV;

   logic             clock;
   logic             reset_n;
   logic             enable;
   logic             done;
   logic [WIDTH-1:0] data;
   logic             audio_out;
   logic [LW-1:0]    level;
   logic             overflow;
   logic             underrun;

   pdm_audio_out #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .done      (done),
      .data      (data),
      .audio_out (audio_out),
      .level     (level),
      .overflow  (overflow),
      .underrun  (underrun)
   );

   typedef struct {
      logic a;
      int   lvl;
      logic ovf;
      logic und;
      int   cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   cycle  = 0;

   // Reference model: a queue of buffered words, the word being played and
   // how many cycles into it playback is.
   logic [WIDTH-1:0] m_fifo[$];
   bit               m_play = 0;
   logic [WIDTH-1:0] m_cur  = '0;
   int               m_t    = 0;
   logic             m_ovf  = 0;
   logic             m_und  = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic model(input logic en, input logic dn, input logic rn, input logic [WIDTH-1:0] d);
      m_ovf = 1'b0;
      m_und = 1'b0;
      if (!rn) begin
         m_fifo.delete();
         m_play = 0;
         m_t    = 0;
      end else if (!en) begin
         m_play = 0;
         m_t    = 0;
      end else begin
         if (m_play && m_t < WORD_CYC - 1) begin
            m_t++;
         end else if (m_fifo.size() > 0) begin
            m_cur  = m_fifo.pop_front();
            m_play = 1;
            m_t    = 0;
         end else if (m_play) begin
            m_play = 0;
            m_und  = 1'b1;
         end
         if (dn) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic en, input logic dn, input logic rn, input logic [WIDTH-1:0] d);
      exp_t e;
      enable  = en;
      done    = dn;
      reset_n = rn;
      data    = d;
      model(en, dn, rn, d);
      e.a   = m_play ? m_cur[WIDTH-1 - m_t / CLK_DIV] : 1'b0;
      e.lvl = m_fifo.size();
      e.ovf = m_ovf;
      e.und = m_und;
      e.cyc = cycle;
      @(posedge clock);
      exp_q.push_back(e);
      cycle++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b1, '0);
   endtask

   // Monitor: one expected entry per clock edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (audio_out === e.a && level === LW'(e.lvl) && overflow === e.ovf && underrun === e.und)
               passes++;
            else
               $display("FAIL outputs cycle %0d: got audio_out=%b level=%0d overflow=%b underrun=%b, expected audio_out=%b level=%0d overflow=%b underrun=%b",
                        e.cyc, audio_out, level, overflow, underrun, e.a, e.lvl, e.ovf, e.und);
         end
      end
   end

   initial begin
      int guard;
      int thr;
      enable  = 1'b0;
      done    = 1'b0;
      reset_n = 1'b0;
      data    = '0;

      repeat (3) step(1'b0, 1'b0, 1'b0, '0);

      // Single word with a known pattern, then underrun.
      step(1'b1, 1'b1, 1'b1, 16'hA5C3);
      idle(WORD_CYC + 5);

      // Two words three cycles apart play gaplessly.
      step(1'b1, 1'b1, 1'b1, 16'hFFFF);
      idle(2);
      step(1'b1, 1'b1, 1'b1, 16'h0000);
      idle(2 * WORD_CYC + 5);

      // Six consecutive writes: fill and one overflow.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, WIDTH'($urandom));

      // Write landing exactly on the word-end pop edge of a full FIFO.
      guard = 0;
      while (!(m_play && m_t == WORD_CYC - 1) && guard < 2000) begin
         idle(1);
         guard++;
      end
      step(1'b1, 1'b1, 1'b1, WIDTH'($urandom));

      // Drop enable mid-word with two words buffered, then resume.
      guard = 0;
      while (!(m_fifo.size() == 2 && m_t == 50) && guard < 2000) begin
         idle(1);
         guard++;
      end
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
      step(1'b0, 1'b0, 1'b1, '0);
      idle(3 * WORD_CYC);

      // Reset mid-word with three words buffered.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
      idle(40);
      step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
      idle(20);

      // Random traffic with varying write rates, enable drops and resets.
      for (int i = 0; i < 4000; i++) begin
         thr = (i < 1500) ? 140 : ((i < 3000) ? 40 : 200);
         step(logic'($urandom_range(0, 199) != 0),
              logic'($urandom_range(0, thr - 1) == 0),
              logic'($urandom_range(0, 1999) != 0),
              WIDTH'($urandom));
      end
      idle(3);

      repeat (3) @(negedge clock);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
